// File: rtl/n64_pi_master_pkg.sv
// Shared timing defaults and counter helpers for the N64 PI bus initiator.
package n64_pi_master_pkg;

  localparam int unsigned PI_T_ALE     = 4;
  localparam int unsigned PI_T_PULSE   = 8;
  localparam int unsigned PI_T_RELEASE = 4;
  localparam int unsigned PI_T_LINGER  = 16;

  localparam int unsigned CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  // A phase lasting N clocks loads N-1; the timer flags done on its last clock.
  function automatic cnt_t cnt_load(input int unsigned clocks);
    return cnt_t'(clocks - 1);
  endfunction

endpackage

// File: rtl/n64_pi_master_timer.sv
// Loadable 8-bit down-counter; done_o is high while the count sits at zero.
module n64_pi_master_timer
  import n64_pi_master_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  cnt_t load_val_i,
  output logic done_o
);

  cnt_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/n64_pi_master.sv
// N64 PI bus initiator: one 32-bit request becomes two 16-bit PI halfword transfers.
// Define N64_PI_MASTER_BURST_EN to keep the bus latched between sequential accesses.
module n64_pi_master
  import n64_pi_master_pkg::*;
#(
  parameter int unsigned T_ALE     = PI_T_ALE,
  parameter int unsigned T_PULSE   = PI_T_PULSE,
  parameter int unsigned T_RELEASE = PI_T_RELEASE,
  parameter int unsigned T_LINGER  = PI_T_LINGER
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_write,
  output logic        o_busy,
  output logic        o_ack,
  input  logic [31:0] i_address,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  output logic        o_n64_pi_aleh,
  output logic        o_n64_pi_alel,
  output logic        o_n64_pi_read,
  output logic        o_n64_pi_write,
  inout  wire  [15:0] io_n64_pi_ad
);

  if (T_ALE == 0 || T_ALE > 255 || T_PULSE == 0 || T_PULSE > 255 ||
      T_RELEASE == 0 || T_RELEASE > 255 || T_LINGER == 0 || T_LINGER > 255) begin : g_bad_param
    $error("n64_pi_master: timing parameters must lie in 1..255");
  end

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_ADDR_H   = 4'd1;
  localparam logic [3:0] ST_ADDR_L   = 4'd2;
  localparam logic [3:0] ST_SETTLE   = 4'd3;
  localparam logic [3:0] ST_STROBE1  = 4'd4;
  localparam logic [3:0] ST_RELEASE1 = 4'd5;
  localparam logic [3:0] ST_STROBE2  = 4'd6;
  localparam logic [3:0] ST_RELEASE2 = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;
`ifdef N64_PI_MASTER_BURST_EN
  localparam logic [3:0] ST_LATCHED  = 4'd9;
  localparam logic [3:0] ST_UNLATCH  = 4'd10;
`endif

  logic [3:0]  state_q, state_d;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [15:0] rd_hi_q, rd_lo_q;
  logic        wr_q;
  logic        accept;
  logic        tmr_done;
  cnt_t        tmr_val;
  logic        ad_oe;
  logic [15:0] ad_out;
  logic        unused_addr_lsbs;

  assign unused_addr_lsbs = ^i_address[1:0];

`ifdef N64_PI_MASTER_BURST_EN
  logic resume_q;
  logic addr_match;
  assign addr_match = ({i_address[31:2], 2'b00} == addr_q + 32'd4) && (i_write == wr_q);
`endif

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (i_request) begin
        accept  = 1'b1;
        state_d = ST_ADDR_H;
      end
      ST_ADDR_H:   if (tmr_done) state_d = ST_ADDR_L;
      ST_ADDR_L:   if (tmr_done) state_d = ST_SETTLE;
      ST_SETTLE:   if (tmr_done) state_d = ST_STROBE1;
      ST_STROBE1:  if (tmr_done) state_d = ST_RELEASE1;
      ST_RELEASE1: if (tmr_done) state_d = ST_STROBE2;
      ST_STROBE2:  if (tmr_done) state_d = ST_RELEASE2;
      ST_RELEASE2: if (tmr_done) state_d = ST_DONE;
`ifdef N64_PI_MASTER_BURST_EN
      ST_DONE:     state_d = ST_LATCHED;
      // A request landing on the linger expiry clock takes the full address phase.
      ST_LATCHED: begin
        if (i_request) begin
          accept  = 1'b1;
          state_d = (addr_match && !tmr_done) ? ST_STROBE1 : ST_UNLATCH;
        end else if (tmr_done) begin
          state_d = ST_UNLATCH;
        end
      end
      ST_UNLATCH:  state_d = resume_q ? ST_ADDR_H : ST_IDLE;
`else
      ST_DONE:     state_d = ST_IDLE;
`endif
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_val = '0;
    case (state_d)
      ST_ADDR_H, ST_ADDR_L, ST_SETTLE: tmr_val = cnt_load(T_ALE);
      ST_STROBE1, ST_STROBE2:          tmr_val = cnt_load(T_PULSE);
      ST_RELEASE1, ST_RELEASE2:        tmr_val = cnt_load(T_RELEASE);
`ifdef N64_PI_MASTER_BURST_EN
      ST_LATCHED:                      tmr_val = cnt_load(T_LINGER);
`endif
      default:                         tmr_val = '0;
    endcase
  end

  n64_pi_master_timer u_timer (
    .clk_i      (i_clk),
    .rst_ni     (i_reset_n),
    .load_i     (state_d != state_q),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      rd_hi_q <= '0;
      rd_lo_q <= '0;
      data_q  <= '0;
`ifdef N64_PI_MASTER_BURST_EN
      resume_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= {i_address[31:2], 2'b00};
        wdata_q <= i_data;
        wr_q    <= i_write;
      end
      // Sample on the last clock of each strobe while /READ is still low.
      if (state_q == ST_STROBE1 && tmr_done && !wr_q) rd_hi_q <= io_n64_pi_ad;
      if (state_q == ST_STROBE2 && tmr_done && !wr_q) rd_lo_q <= io_n64_pi_ad;
      if (state_q == ST_RELEASE2 && tmr_done && !wr_q) data_q <= {rd_hi_q, rd_lo_q};
`ifdef N64_PI_MASTER_BURST_EN
      resume_q <= accept;
`endif
    end
  end

  always_comb begin
    o_n64_pi_aleh  = 1'b0;
    o_n64_pi_alel  = 1'b1;
    o_n64_pi_read  = 1'b1;
    o_n64_pi_write = 1'b1;
    ad_oe          = 1'b0;
    ad_out         = '0;
    o_busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_ADDR_H: begin
        o_n64_pi_aleh = 1'b1;
        ad_oe         = 1'b1;
        ad_out        = addr_q[31:16];
      end
      ST_ADDR_L: begin
        ad_oe  = 1'b1;
        ad_out = addr_q[15:0];
      end
      ST_SETTLE, ST_RELEASE1: begin
        o_n64_pi_alel = 1'b0;
        ad_oe         = wr_q;
        ad_out        = wdata_q[31:16];
      end
      ST_STROBE1: begin
        o_n64_pi_alel  = 1'b0;
        o_n64_pi_read  = wr_q;
        o_n64_pi_write = !wr_q;
        ad_oe          = wr_q;
        ad_out         = wdata_q[31:16];
      end
      ST_STROBE2: begin
        o_n64_pi_alel  = 1'b0;
        o_n64_pi_read  = wr_q;
        o_n64_pi_write = !wr_q;
        ad_oe          = wr_q;
        ad_out         = wdata_q[15:0];
      end
      ST_RELEASE2: begin
        o_n64_pi_alel = 1'b0;
        ad_oe         = wr_q;
        ad_out        = wdata_q[15:0];
      end
      ST_DONE: o_n64_pi_alel = 1'b0;
`ifdef N64_PI_MASTER_BURST_EN
      ST_LATCHED: begin
        o_n64_pi_alel = 1'b0;
        o_busy        = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  assign io_n64_pi_ad = ad_oe ? ad_out : 16'hzzzz;
  assign o_ack        = (state_q == ST_DONE);
  assign o_data       = data_q;

endmodule

// File: tb/tb_n64_pi_master.sv
// Directed bench for n64_pi_master with a behavioural PI responder and a latency/data scoreboard.
module tb_n64_pi_master;

`ifdef N64_PI_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif
  localparam int FULL = 36;
  localparam int MISS = BURST ? 37 : 36;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        request, write;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        busy, ack, aleh, alel, rd_n, wr_n;
  wire  [15:0] pi_ad;
  logic [15:0] rsp_ad;

  always #5 clk = ~clk;

  assign pi_ad = (!rd_n) ? rsp_ad : 16'hzzzz;

  n64_pi_master dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_request      (request),
    .i_write        (write),
    .o_busy         (busy),
    .o_ack          (ack),
    .i_address      (address),
    .i_data         (wdata),
    .o_data         (rdata),
    .o_n64_pi_aleh  (aleh),
    .o_n64_pi_alel  (alel),
    .o_n64_pi_read  (rd_n),
    .o_n64_pi_write (wr_n),
    .io_n64_pi_ad   (pi_ad)
  );

  int n_vec  = 0;
  int n_miss = 0;
  string cur_test = "reset";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s/%s: observed %h expected %h", cur_test, tag, obs, exp);
    end
  endtask

  // Behavioural responder: latches the address on ALEL fall, auto-increments per halfword.
  logic [15:0] mem [logic [31:0]];
  logic [31:0] rsp_addr = '0;
  logic [15:0] lat_hi = '0, lat_lo = '0, lo_tmp = '0;
  logic        prev_alel = 1'b1, prev_rd = 1'b1, prev_wr = 1'b1;
  logic [15:0] wr_log[$];

  function automatic logic [15:0] rd16(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  always @(negedge clk) begin
    if (aleh && alel) lat_hi = pi_ad;
    if (!aleh && alel) lo_tmp = pi_ad;
    if (prev_alel && !alel) begin
      lat_lo   = lo_tmp;
      rsp_addr = {lat_hi, lo_tmp};
    end
    if (!prev_wr && wr_n) begin
      mem[rsp_addr] = pi_ad;
      wr_log.push_back(pi_ad);
      rsp_addr = rsp_addr + 32'd2;
    end
    if (!prev_rd && rd_n) rsp_addr = rsp_addr + 32'd2;
    if (!rd_n) rsp_ad = rd16(rsp_addr);
    prev_alel = alel;
    prev_rd   = rd_n;
    prev_wr   = wr_n;
  end

  // Scoreboard: stimulus pushes expectations, the monitor pops one per ack.
  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0, n_ack = 0, n_acc = 0;

  always @(negedge clk) begin
    exp_t e;
    int   a;
    cyc++;
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if (ack) begin
        n_ack++;
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          check("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("ack_latency", cyc - 1 - a, e.lat);
          if (e.rd) check("read_data", rdata, e.data);
        end
      end
      if (request && !busy) begin
        acc_q.push_back(cyc);
        n_acc++;
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_d, input int lat, input bit push);
    write   = wr;
    address = addr;
    wdata   = wd;
    request = 1'b1;
    if (push) exp_q.push_back('{rd: !wr, data: exp_d, lat: lat});
    @(posedge clk);
    #1 request = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 200);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, a0, c0;
    request = 1'b0;
    write   = 1'b0;
    address = '0;
    wdata   = '0;
    rsp_ad  = '0;
    mem[32'h1000_0000] = 16'h8037;
    mem[32'h1000_0002] = 16'h1240;
    mem[32'h1000_0004] = 16'h1122;
    mem[32'h1000_0006] = 16'h3344;
    mem[32'h1000_0100] = 16'hCAFE;
    mem[32'h1000_0102] = 16'hF00D;

    repeat (3) @(posedge clk);
    #1;
    check("aleh", 32'(aleh), 32'd0);
    check("alel", 32'(alel), 32'd1);
    check("read_n", 32'(rd_n), 32'd1);
    check("write_n", 32'(wr_n), 32'd1);
    check("busy", 32'(busy), 32'd0);
    check("ack", 32'(ack), 32'd0);
    check("data", rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    cur_test = "t1_read";
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h8037_1240, FULL, 1'b1);
    wait_idle("done");
    check("addr_hi", 32'(lat_hi), 32'h1000);
    check("addr_lo", 32'(lat_lo), 32'h0000);
    check("alel_after", 32'(alel), BURST ? 32'd0 : 32'd1);
    check("aleh_after", 32'(aleh), 32'd0);

    cur_test = "t2_write";
    n0 = wr_log.size();
    issue(1'b1, 32'h1000_0013, 32'hDEAD_BEEF, 32'h0, MISS, 1'b1);
    wait_idle("done");
    check("addr_lo", 32'(lat_lo), 32'h0010);
    check("pulses", wr_log.size() - n0, 32'd2);
    check("half0", 32'(wr_log[n0]), 32'hDEAD);
    check("half1", 32'(wr_log[n0+1]), 32'hBEEF);
    cur_test = "t2_readback";
    issue(1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, MISS, 1'b1);
    wait_idle("done");

    // Held request: one access per 38-clock busy period, accepts on edges 0, 38, 76 of 80.
    cur_test = "t3_held";
    a0 = n_ack;
    c0 = n_acc;
    for (int i = 0; i < 3; i++) exp_q.push_back('{rd: 1'b1, data: 32'h8037_1240, lat: MISS});
    write   = 1'b0;
    address = 32'h1000_0000;
    request = 1'b1;
    repeat (80) @(posedge clk);
    #1 request = 1'b0;
    wait_idle("done");
    check("acks", n_ack - a0, 32'd3);
    check("accepts", n_acc - c0, 32'd3);

    cur_test = "t4_reset";
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b0);
    repeat (28) @(posedge clk);
    #1;
    check("in_strobe2", 32'(rd_n), 32'd0);
    rst_n = 1'b0;
    #1;
    check("aleh", 32'(aleh), 32'd0);
    check("alel", 32'(alel), 32'd1);
    check("read_n", 32'(rd_n), 32'd1);
    check("write_n", 32'(wr_n), 32'd1);
    check("busy", 32'(busy), 32'd0);
    check("ack", 32'(ack), 32'd0);
    check("data", rdata, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cur_test = "t4_after";
    issue(1'b0, 32'h1000_0010, 32'h0, 32'hDEAD_BEEF, FULL, 1'b1);
    wait_idle("done");

`ifdef N64_PI_MASTER_BURST_EN
    cur_test = "t5_burst";
    repeat (20) @(posedge clk);
    #1;
    check("timeout_alel", 32'(alel), 32'd1);
    issue(1'b0, 32'h1000_0000, 32'h0, 32'h8037_1240, 36, 1'b1);
    wait_idle("first");
    check("latched_alel", 32'(alel), 32'd0);
    issue(1'b0, 32'h1000_0004, 32'h0, 32'h1122_3344, 24, 1'b1);
    wait_idle("seq");
    issue(1'b0, 32'h1000_0100, 32'h0, 32'hCAFE_F00D, 37, 1'b1);
    wait_idle("jump");
    check("jump_addr_lo", 32'(lat_lo), 32'h0100);

    cur_test = "t6_linger";
    repeat (20) @(posedge clk);
    #1;
    check("timeout_alel", 32'(alel), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    n0 = wr_log.size();
    issue(1'b1, 32'h1000_0104, 32'h5566_7788, 32'h0, 36, 1'b1);
    wait_idle("write");
    check("half0", 32'(wr_log[n0]), 32'h5566);
    check("half1", 32'(wr_log[n0+1]), 32'h7788);
`endif

    cur_test = "end";
    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
